// File: rtl/seq_mult_hs.sv
// seq_mult_hs: iterative shift-add multiplier with valid/ready handshakes.
// One multiplier bit is consumed per cycle. In signed mode the MSB partial
// product is subtracted, because its weight is -2^(WIDTH-1).
module seq_mult_hs #(
    parameter int WIDTH     = 4,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   z,
    output logic                 busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   z_q;
    logic [WIDTH-1:0]     mplr;
    logic [CW-1:0]        cnt;
    logic                 neg;
    logic                 eff_signed;
    logic                 accept;
    logic                 last;

    // mcand is shifted left and mplr right every BUSY cycle, so the current
    // partial product is always mcand gated by mplr[0]. That avoids a
    // variable-distance barrel shifter.
    assign eff_signed = signed_mode & SIGNED_EN;
    assign accept     = (state == IDLE) && in_valid;
    assign last       = (state == BUSY) && (cnt == LAST);

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign z          = z_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept in IDLE, WIDTH cycles of BUSY, hold DONE
    // until the consumer takes the product.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = BUSY;
            BUSY:    if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Accumulator update for this cycle's multiplier bit. The signed MSB
    // partial product is subtracted instead of added.
    always_comb begin
        acc_next = acc;
        if (mplr[0]) begin
            if (neg && (cnt == LAST)) begin
                acc_next = acc - mcand;
            end else begin
                acc_next = acc + mcand;
            end
        end
    end

    // Datapath registers: operand capture on accept, shift-add while busy,
    // and a product register that only changes on the final BUSY edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            z_q   <= '0;
        end else if (accept) begin
            mcand <= {{WIDTH{a[WIDTH-1] & eff_signed}}, a};
            mplr  <= b;
            acc   <= '0;
            cnt   <= '0;
            neg   <= eff_signed;
        end else if (state == BUSY) begin
            acc   <= acc_next;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + 1'b1;
            if (last) begin
                z_q <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_seq_mult_hs.sv
// tb_seq_mult_hs: self-checking bench for seq_mult_hs.
// Four instances (W=2 unsigned, W=4 signed, W=4 unsigned-only, W=8 signed)
// share operand buses. Each instance has its own in_valid, so only the
// selected one is ever started.
module tb_seq_mult_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  iv;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        sm;
    logic        out_ready;

    logic [3:0]  ir_v;
    logic [3:0]  ov_v;
    logic [3:0]  busy_v;
    logic [3:0]  z0;
    logic [7:0]  z1;
    logic [7:0]  z2;
    logic [15:0] z3;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_mult_hs #(.WIDTH(2), .SIGNED_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir_v[0]),
        .a(a_in[1:0]), .b(b_in[1:0]), .signed_mode(sm),
        .out_valid(ov_v[0]), .out_ready(out_ready), .z(z0), .busy(busy_v[0])
    );

    seq_mult_hs #(.WIDTH(4), .SIGNED_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir_v[1]),
        .a(a_in[3:0]), .b(b_in[3:0]), .signed_mode(sm),
        .out_valid(ov_v[1]), .out_ready(out_ready), .z(z1), .busy(busy_v[1])
    );

    seq_mult_hs #(.WIDTH(4), .SIGNED_EN(1'b0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir_v[2]),
        .a(a_in[3:0]), .b(b_in[3:0]), .signed_mode(sm),
        .out_valid(ov_v[2]), .out_ready(out_ready), .z(z2), .busy(busy_v[2])
    );

    seq_mult_hs #(.WIDTH(8), .SIGNED_EN(1'b1)) dut3 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir_v[3]),
        .a(a_in), .b(b_in), .signed_mode(sm),
        .out_valid(ov_v[3]), .out_ready(out_ready), .z(z3), .busy(busy_v[3])
    );

    function automatic int w_of(input int s);
        case (s)
            0:       return 2;
            3:       return 8;
            default: return 4;
        endcase
    endfunction

    function automatic bit signed_en_of(input int s);
        return (s == 1) || (s == 3);
    endfunction

    function automatic logic [15:0] z_of(input int s);
        case (s)
            0:       return {12'b0, z0};
            1:       return {8'b0, z1};
            2:       return {8'b0, z2};
            default: return z3;
        endcase
    endfunction

    // Reference: interpret operands as integers, multiply, truncate to 2W bits.
    function automatic logic [15:0] ref_mul(input int w, input bit eff,
                                            input logic [7:0] av, input logic [7:0] bv);
        longint x;
        longint y;
        longint p;
        longint m;
        m = (longint'(1) << w) - 1;
        x = longint'(av) & m;
        y = longint'(bv) & m;
        if (eff && (((x >> (w - 1)) & 1) == 1)) x = x - (longint'(1) << w);
        if (eff && (((y >> (w - 1)) & 1) == 1)) y = y - (longint'(1) << w);
        p = (x * y) & ((longint'(1) << (2 * w)) - 1);
        return p[15:0];
    endfunction

    // One complete transaction on instance sel. Called and returning at
    // posedge+1. The product is held for 'stall' cycles before it is taken.
    // With hold_valid set, in_valid stays high through the stall with other
    // operands, which must not start a new operation.
    task automatic run_op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                          input logic smv, input int stall, input bit hold_valid,
                          input string name);
        logic [15:0] exp_z;
        int          n;
        int          w;
        w     = w_of(sel);
        exp_z = ref_mul(w, smv && signed_en_of(sel), av, bv);

        n = 0;
        while (!ir_v[sel] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (ir_v[sel] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s ready_timeout: in_ready=%b required 1", name, ir_v[sel]);
            return;
        end

        iv[sel] = 1'b1;
        a_in    = av;
        b_in    = bv;
        sm      = smv;
        @(posedge clk); #1;
        iv[sel] = 1'b0;
        a_in    = 8'($urandom);
        b_in    = 8'($urandom);
        sm      = 1'($urandom);

        vectors++;
        if (ir_v[sel] !== 1'b0 || busy_v[sel] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s busy_after_accept: in_ready=%b busy=%b required 0/1",
                     name, ir_v[sel], busy_v[sel]);
        end

        n = 0;
        while (!ov_v[sel] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        // out_valid appears after edge E0+W, so the first handshake edge is E0+W+1.
        vectors++;
        if (ov_v[sel] !== 1'b1 || n != w) begin
            miscompares++;
            $display("[TB] FAIL %s latency: out_valid=%b after %0d edges required 1 after %0d",
                     name, ov_v[sel], n, w);
            if (ov_v[sel] !== 1'b1) return;
        end

        vectors++;
        if (z_of(sel) !== exp_z) begin
            miscompares++;
            $display("[TB] FAIL %s product a=%h b=%h sm=%b: z=%h required %h",
                     name, av, bv, smv, z_of(sel), exp_z);
        end

        for (int k = 0; k < stall; k++) begin
            if (hold_valid) begin
                iv[sel] = 1'b1;
                a_in    = 8'($urandom);
                b_in    = 8'($urandom);
            end
            @(posedge clk); #1;
            vectors++;
            if (ov_v[sel] !== 1'b1 || ir_v[sel] !== 1'b0 || z_of(sel) !== exp_z) begin
                miscompares++;
                $display("[TB] FAIL %s stall%0d: out_valid=%b in_ready=%b z=%h required 1/0/%h",
                         name, k, ov_v[sel], ir_v[sel], z_of(sel), exp_z);
            end
        end

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        iv[sel]   = 1'b0;
        vectors++;
        if (ov_v[sel] !== 1'b0 || ir_v[sel] !== 1'b1 || busy_v[sel] !== 1'b0 ||
            z_of(sel) !== exp_z) begin
            miscompares++;
            $display("[TB] FAIL %s handshake: out_valid=%b in_ready=%b busy=%b z=%h required 0/1/0/%h",
                     name, ov_v[sel], ir_v[sel], busy_v[sel], z_of(sel), exp_z);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 4; s++) begin
            vectors++;
            if (ir_v[s] !== 1'b1 || ov_v[s] !== 1'b0 || busy_v[s] !== 1'b0 ||
                z_of(s) !== 16'h0) begin
                miscompares++;
                $display("[TB] FAIL reset_state dut%0d: in_ready=%b out_valid=%b busy=%b z=%h required 1/0/0/0",
                         s, ir_v[s], ov_v[s], busy_v[s], z_of(s));
            end
        end
    endtask

    task automatic test_exhaustive_w2();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                run_op(0, 8'(i), 8'(j), 1'b0, 0, 1'b0, "w2_exhaustive");
            end
        end
    endtask

    task automatic test_unsigned_w4();
        run_op(1, 8'h0F, 8'h0F, 1'b0, 0, 1'b0, "u4_15x15");
        run_op(1, 8'h00, 8'h0D, 1'b0, 0, 1'b0, "u4_0x13");
    endtask

    task automatic test_signed_w4();
        run_op(1, 8'h08, 8'h08, 1'b1, 0, 1'b0, "s4_m8xm8");
        run_op(1, 8'h0F, 8'h07, 1'b1, 0, 1'b0, "s4_m1x7");
        run_op(1, 8'h07, 8'h08, 1'b1, 0, 1'b0, "s4_7xm8");
        run_op(2, 8'h0F, 8'h0F, 1'b1, 0, 1'b0, "se0_15x15");
    endtask

    // A second in_valid while busy must be ignored.
    task automatic test_ignore_busy();
        iv[2] = 1'b1;
        a_in  = 8'h0F;
        b_in  = 8'h0F;
        sm    = 1'b0;
        @(posedge clk); #1;
        a_in  = 8'h01;
        b_in  = 8'h01;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (ir_v[2] !== 1'b0 || busy_v[2] !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL ignore_busy cycle%0d: in_ready=%b busy=%b required 0/1",
                         k, ir_v[2], busy_v[2]);
            end
        end
        iv[2] = 1'b0;
        for (int k = 0; k < 20 && !ov_v[2]; k++) begin
            @(posedge clk); #1;
        end
        vectors++;
        if (ov_v[2] !== 1'b1 || z2 !== 8'hE1) begin
            miscompares++;
            $display("[TB] FAIL ignore_busy product: out_valid=%b z=%h required 1/e1", ov_v[2], z2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (busy_v[2] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ignore_busy restart: busy=%b required 0", busy_v[2]);
        end
    endtask

    task automatic test_backpressure();
        run_op(1, 8'h06, 8'h05, 1'b0, 5, 1'b1, "backpressure");
        vectors++;
        if (busy_v[1] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL backpressure no_early_accept: busy=%b required 0", busy_v[1]);
        end
        run_op(1, 8'h03, 8'h0D, 1'b1, 0, 1'b0, "after_backpressure");
    endtask

    task automatic test_reset_mid_op();
        iv[1] = 1'b1;
        a_in  = 8'h09;
        b_in  = 8'h09;
        sm    = 1'b0;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        vectors++;
        if (ir_v[1] !== 1'b1 || ov_v[1] !== 1'b0 || busy_v[1] !== 1'b0 || z1 !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_op: in_ready=%b out_valid=%b busy=%b z=%h required 1/0/0/00",
                     ir_v[1], ov_v[1], busy_v[1], z1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(1, 8'h03, 8'h05, 1'b0, 0, 1'b0, "post_reset_3x5");
    endtask

    task automatic test_back_to_back(input int sel, input int count);
        int stall;
        for (int i = 0; i < count; i++) begin
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_op(sel, 8'($urandom), 8'($urandom), 1'($urandom), stall, 1'b0, "random");
        end
    endtask

    initial begin
        rst       = 1'b1;
        iv        = 4'b0;
        a_in      = 8'h0;
        b_in      = 8'h0;
        sm        = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        test_exhaustive_w2();
        test_unsigned_w4();
        test_signed_w4();
        test_ignore_busy();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back(1, 1000);
        test_back_to_back(3, 1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
